// File: rtl/mul_booth_pipe.sv
// mul_booth_pipe: radix-4 Booth multiplier, CSA (Wallace) reduction, 4-stage
// valid/ready pipeline with per-stage stall and bubble collapse.
// Optional feature: define MUL_BOOTH_FLUSH_EN to add a synchronous flush input.
module mul_booth_pipe #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
`ifdef MUL_BOOTH_FLUSH_EN
  input  logic               flush,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [TAG_W-1:0]   out_tag
);

  // Row count left after lv levels of 3:2 compression starting from n0 rows.
  function automatic int unsigned rows_after(input int unsigned n0, input int unsigned lv);
    int unsigned n;
    n = n0;
    for (int unsigned i = 0; i < lv; i++) n = n - n / 3;
    return n;
  endfunction

  // Number of 3:2 levels needed to bring n0 rows down to at most lim rows.
  function automatic int unsigned levels_to(input int unsigned n0, input int unsigned lim);
    int unsigned n;
    int unsigned lv;
    n  = n0;
    lv = 0;
    while (n > lim) begin
      n  = n - n / 3;
      lv = lv + 1;
    end
    return lv;
  endfunction

  localparam int unsigned PW  = 2 * WIDTH;           // product width
  localparam int unsigned XW  = WIDTH + 2;           // extended operand width
  localparam int unsigned NG  = XW / 2;              // Booth groups
  localparam int unsigned NPP = NG + 1;              // partial products + injection row
  localparam int unsigned L1  = levels_to(NPP, 12);  // CSA levels in S1
  localparam int unsigned N1  = rows_after(NPP, L1); // rows registered after S1
  localparam int unsigned L2  = levels_to(N1, 2);    // CSA levels in S2

  logic v0, v1, v2, v3;
  logic adv0, adv1, adv2, adv3;
  logic in_xfer;
  logic do_flush;

  logic [WIDTH-1:0] s0_a, s0_b;
  logic             s0_signed;
  logic [TAG_W-1:0] s0_tag, s1_tag, s2_tag;
  logic [PW-1:0]    s1_rows [N1];
  logic [PW-1:0]    s2_sum, s2_carry;

  logic [PW-1:0]    a_sx;
  logic [XW:0]      b_pad;
  logic [2:0]       grp;
  logic             neg, one, two;
  logic [PW-1:0]    mag, inj;
  logic [PW-1:0]    t1_cur [NPP];
  logic [PW-1:0]    t1_nxt [NPP];
  logic [PW-1:0]    c1x, c1y, c1z;
  int unsigned      t1_n;
  logic [PW-1:0]    t2_cur [N1];
  logic [PW-1:0]    t2_nxt [N1];
  logic [PW-1:0]    c2x, c2y, c2z;
  int unsigned      t2_n;

`ifdef MUL_BOOTH_FLUSH_EN
  assign do_flush = flush;
`else
  assign do_flush = 1'b0;
`endif

  assign out_valid = v3;

  // Stall chain: a stage moves when it holds data and the next slot frees up.
  always_comb begin
    adv3     = v3 & out_ready;
    adv2     = v2 & (~v3 | adv3);
    adv1     = v1 & (~v2 | adv2);
    adv0     = v0 & (~v1 | adv1);
    in_ready = ~do_flush & (~v0 | adv0);
    in_xfer  = in_valid & in_ready;
  end

  // Stage valid flags; reset wins over flush, both empty the pipe.
  always_ff @(posedge clk) begin
    if (rst || do_flush) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v0 <= in_xfer | (v0 & ~adv0);
      v1 <= adv0 | (v1 & ~adv1);
      v2 <= adv1 | (v2 & ~adv2);
      v3 <= adv2 | (v3 & ~adv3);
    end
  end

  // S1 combinational: Booth recode of S0 operands then first CSA levels.
  always_comb begin
    a_sx  = {{(PW - WIDTH){s0_signed & s0_a[WIDTH-1]}}, s0_a};
    b_pad = {{2{s0_signed & s0_b[WIDTH-1]}}, s0_b, 1'b0};
    grp   = '0;
    neg   = 1'b0;
    one   = 1'b0;
    two   = 1'b0;
    mag   = '0;
    inj   = '0;
    c1x   = '0;
    c1y   = '0;
    c1z   = '0;
    for (int unsigned r = 0; r < NPP; r++) begin
      t1_cur[r] = '0;
      t1_nxt[r] = '0;
    end
    for (int unsigned j = 0; j < NG; j++) begin
      grp = b_pad[2*j +: 3];
      neg = grp[2] & ~(grp[1] & grp[0]);
      one = grp[1] ^ grp[0];
      two = (grp[2] & ~grp[1] & ~grp[0]) | (~grp[2] & grp[1] & grp[0]);
      mag = two ? (a_sx << 1) : (one ? a_sx : '0);
      // Negative digit: invert here, the +1 lands in the injection row.
      t1_cur[j] = (neg ? ~mag : mag) << (2 * j);
      inj = inj | (PW'(neg) << (2 * j));
    end
    t1_cur[NG] = inj;
    t1_n = NPP;
    for (int unsigned l = 0; l < L1; l++) begin
      for (int unsigned r = 0; r < NPP; r++) t1_nxt[r] = '0;
      for (int unsigned g = 0; g < NPP / 3; g++) begin
        if (g < t1_n / 3) begin
          c1x = t1_cur[3*g];
          c1y = t1_cur[3*g+1];
          c1z = t1_cur[3*g+2];
          t1_nxt[2*g]   = c1x ^ c1y ^ c1z;
          t1_nxt[2*g+1] = ((c1x & c1y) | (c1x & c1z) | (c1y & c1z)) << 1;
        end
      end
      for (int unsigned r = 0; r < 2; r++) begin
        if (r < t1_n % 3) t1_nxt[2*(t1_n/3)+r] = t1_cur[3*(t1_n/3)+r];
      end
      t1_n   = t1_n - t1_n / 3;
      t1_cur = t1_nxt;
    end
  end

  // S2 combinational: remaining CSA levels down to one sum/carry pair.
  always_comb begin
    c2x = '0;
    c2y = '0;
    c2z = '0;
    for (int unsigned r = 0; r < N1; r++) begin
      t2_cur[r] = s1_rows[r];
      t2_nxt[r] = '0;
    end
    t2_n = N1;
    for (int unsigned l = 0; l < L2; l++) begin
      for (int unsigned r = 0; r < N1; r++) t2_nxt[r] = '0;
      for (int unsigned g = 0; g < N1 / 3; g++) begin
        if (g < t2_n / 3) begin
          c2x = t2_cur[3*g];
          c2y = t2_cur[3*g+1];
          c2z = t2_cur[3*g+2];
          t2_nxt[2*g]   = c2x ^ c2y ^ c2z;
          t2_nxt[2*g+1] = ((c2x & c2y) | (c2x & c2z) | (c2y & c2z)) << 1;
        end
      end
      for (int unsigned r = 0; r < 2; r++) begin
        if (r < t2_n % 3) t2_nxt[2*(t2_n/3)+r] = t2_cur[3*(t2_n/3)+r];
      end
      t2_n   = t2_n - t2_n / 3;
      t2_cur = t2_nxt;
    end
  end

  // Pipeline data registers; they load only when their stage is filled.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      s0_a      <= in_a;
      s0_b      <= in_b;
      s0_signed <= in_signed;
      s0_tag    <= in_tag;
    end
    if (adv0) begin
      for (int unsigned r = 0; r < N1; r++) s1_rows[r] <= t1_cur[r];
      s1_tag <= s0_tag;
    end
    if (adv1) begin
      s2_sum   <= t2_cur[0];
      s2_carry <= t2_cur[1];
      s2_tag   <= s1_tag;
    end
  end

  // S3: carry-propagate add into the held output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_prod <= '0;
      out_tag  <= '0;
    end else if (adv2) begin
      out_prod <= s2_sum + s2_carry;
      out_tag  <= s2_tag;
    end
  end

endmodule

// File: tb/tb_mul_booth_pipe.sv
// Self-checking bench for mul_booth_pipe (64-bit main instance, two 8-bit
// instances for the exhaustive sweep). Flush test built with MUL_BOOTH_FLUSH_EN.
`timescale 1ns/1ps
module tb_mul_booth_pipe;
  localparam int unsigned W  = 64;
  localparam int unsigned TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, in_signed;
  logic [W-1:0]  in_a, in_b;
  logic [TW-1:0] in_tag, out_tag;
  logic          out_valid, out_ready;
  logic [2*W-1:0] out_prod;
`ifdef MUL_BOOTH_FLUSH_EN
  logic          flush;
`endif

  logic          e_valid, e_oready;
  logic [7:0]    e_a, e_b;
  logic [TW-1:0] e_tag;
  logic          es_ready, eu_ready, es_ovalid, eu_ovalid;
  logic [15:0]   es_prod, eu_prod;
  logic [TW-1:0] es_tag, eu_tag;

  int errors = 0;
  int checks = 0;

  mul_booth_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
`ifdef MUL_BOOTH_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_tag(out_tag)
  );

  mul_booth_pipe #(.WIDTH(8), .TAG_W(TW)) dut8s (
    .clk(clk), .rst(rst),
`ifdef MUL_BOOTH_FLUSH_EN
    .flush(1'b0),
`endif
    .in_valid(e_valid), .in_ready(es_ready), .in_signed(1'b1),
    .in_a(e_a), .in_b(e_b), .in_tag(e_tag),
    .out_valid(es_ovalid), .out_ready(e_oready),
    .out_prod(es_prod), .out_tag(es_tag)
  );

  mul_booth_pipe #(.WIDTH(8), .TAG_W(TW)) dut8u (
    .clk(clk), .rst(rst),
`ifdef MUL_BOOTH_FLUSH_EN
    .flush(1'b0),
`endif
    .in_valid(e_valid), .in_ready(eu_ready), .in_signed(1'b0),
    .in_a(e_a), .in_b(e_b), .in_tag(e_tag),
    .out_valid(eu_ovalid), .out_ready(e_oready),
    .out_prod(eu_prod), .out_tag(eu_tag)
  );

  // Reference: extend each operand to the product width, multiply modulo 2^128.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
    logic [2*W-1:0] xa, xb;
    xa = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    xb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return xa * xb;
  endfunction

  function automatic logic [15:0] ref_mul8(input logic [7:0] a, input logic [7:0] b,
                                           input logic s);
    logic [15:0] xa, xb;
    xa = s ? {{8{a[7]}}, a} : {8'd0, a};
    xb = s ? {{8{b[7]}}, b} : {8'd0, b};
    return xa * xb;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b0; e_valid = 1'b0; e_oready = 1'b1; e_a = '0; e_b = '0; e_tag = '0;
`ifdef MUL_BOOTH_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_prod !== '0) begin errors++; $display("FAIL reset_out_prod got=%h want=0", out_prod); end
    checks++; if (out_tag !== '0) begin errors++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (es_ovalid !== 1'b0 || eu_ovalid !== 1'b0) begin
      errors++; $display("FAIL reset_w8_valid got=%b%b want=00", es_ovalid, eu_ovalid);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0]   da [6];
    logic [W-1:0]   db [6];
    logic           ds [6];
    logic [2*W-1:0] dp [6];
    logic           exp_v;
    da[0] = '1;                 db[0] = '1;                 ds[0] = 1'b1; dp[0] = 128'd1;
    da[1] = '1;                 db[1] = '1;                 ds[1] = 1'b0;
    dp[1] = 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
    da[2] = '1;                 db[2] = '1;                 ds[2] = 1'b1; dp[2] = 128'd1;
    da[3] = 64'h8000_0000_0000_0000; db[3] = 64'h8000_0000_0000_0000; ds[3] = 1'b1;
    dp[3] = 128'h4000_0000_0000_0000_0000_0000_0000_0000;
    da[4] = 64'h8000_0000_0000_0000; db[4] = 64'h8000_0000_0000_0000; ds[4] = 1'b0;
    dp[4] = 128'h4000_0000_0000_0000_0000_0000_0000_0000;
    da[5] = 64'h8000_0000_0000_0000; db[5] = 64'd1;          ds[5] = 1'b1;
    dp[5] = 128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_signed = ds[k]; in_a = da[k]; in_b = db[k]; in_tag = TW'(k + 5);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready got=%b want=1", k, in_ready); end
      for (int d = 1; d <= 4; d++) begin
        @(negedge clk);
        if (d == 1) in_valid = 1'b0;
        exp_v = (d == 4);
        checks++; if (out_valid !== exp_v) begin
          errors++; $display("FAIL dir%0d_latency cycle=%0d got=%b want=%b", k, d, out_valid, exp_v);
        end
      end
      checks++; if (out_prod !== dp[k] || out_tag !== TW'(k + 5)) begin
        errors++; $display("FAIL dir%0d_prod got=%h/%h want=%h/%h", k, out_prod, out_tag, dp[k], TW'(k + 5));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0]        a, b;
    logic                s;
    logic [2*W+TW-1:0]   q[$];
    logic [2*W+TW-1:0]   held_val;
    logic                held, exp_ready, in_x, out_x;
    int                  sent, got, occ, cyc;
    sent = 0; got = 0; occ = 0; cyc = 0; held = 1'b0; held_val = '0;
    a = '0; b = '0; s = 1'b0;
    while ((sent < 20 || q.size() > 0) && cyc < 400) begin
      @(negedge clk);
      in_valid = (sent < 20);
      if (sent < 20) begin
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; s = 1'($urandom_range(0, 1));
        in_a = a; in_b = b; in_signed = s; in_tag = TW'(sent);
      end
      out_ready = (cyc < 6) ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      exp_ready = (occ < 4) || out_ready;
      checks++; if (in_ready !== exp_ready) begin
        errors++; $display("FAIL b2b_in_ready cyc=%0d occ=%0d got=%b want=%b", cyc, occ, in_ready, exp_ready);
      end
      if (held) begin
        checks++; if (out_valid !== 1'b1 || {out_prod, out_tag} !== held_val) begin
          errors++; $display("FAIL b2b_stall_hold cyc=%0d got=%b/%h want=1/%h", cyc, out_valid, {out_prod, out_tag}, held_val);
        end
      end
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_spurious cyc=%0d got=%h want=none", cyc, {out_prod, out_tag});
        end else if ({out_prod, out_tag} !== q[0]) begin
          errors++; $display("FAIL b2b_order cyc=%0d got=%h want=%h", cyc, {out_prod, out_tag}, q[0]);
        end
      end
      in_x  = in_valid && exp_ready;
      out_x = out_valid && out_ready;
      held = out_valid && !out_ready;
      held_val = {out_prod, out_tag};
      if (out_x && q.size() > 0) begin void'(q.pop_front()); got++; end
      if (in_x) begin q.push_back({ref_mul(a, b, s), TW'(sent)}); sent++; end
      occ = occ + int'(in_x) - int'(out_x);
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (sent != 20 || got != 20) begin
      errors++; $display("FAIL b2b_count got=%0d/%0d want=20/20", sent, got);
    end
  endtask

  task automatic test_rst_inflight();
    logic [W-1:0]   a, b;
    logic [2*W-1:0] exp_p;
    logic           exp_v;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_signed = 1'b0; in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
      in_tag = TW'(k + 1);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_fill%0d got=%b want=1", k, in_ready); end
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_ghost cycle=%0d got=%b want=0", k, out_valid); end
    end
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    exp_p = ref_mul(a, b, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; in_signed = 1'b1; in_a = a; in_b = b; in_tag = TW'(11);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_next_ready got=%b want=1", in_ready); end
    for (int d = 1; d <= 4; d++) begin
      @(negedge clk);
      if (d == 1) in_valid = 1'b0;
      exp_v = (d == 4);
      checks++; if (out_valid !== exp_v) begin
        errors++; $display("FAIL rst_next_latency cycle=%0d got=%b want=%b", d, out_valid, exp_v);
      end
    end
    checks++; if (out_prod !== exp_p || out_tag !== TW'(11)) begin
      errors++; $display("FAIL rst_next_prod got=%h/%h want=%h/%h", out_prod, out_tag, exp_p, TW'(11));
    end
    @(negedge clk);
  endtask

`ifdef MUL_BOOTH_FLUSH_EN
  task automatic test_flush();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_signed = 1'b1; in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
      in_tag = TW'(k);
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_fill%0d got=%b want=1", k, in_ready); end
    end
    @(negedge clk);
    out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_full got=%b want=1", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_block got=%b want=0", in_ready); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after got=%b want=1", in_ready); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty cycle=%0d got=%b want=0", k, out_valid); end
    end
  endtask
`endif

  task automatic test_exhaustive8();
    logic [15+TW:0] qs[$];
    logic [15+TW:0] qu[$];
    int             i, cyc;
    i = 0; cyc = 0;
    e_oready = 1'b1;
    while ((i < 65536 || qs.size() > 0 || qu.size() > 0) && cyc < 65600) begin
      @(negedge clk);
      e_valid = (i < 65536);
      e_a = 8'(i >> 8); e_b = 8'(i); e_tag = TW'(i);
      #1;
      if (es_ovalid) begin
        checks++;
        if (qs.size() == 0) begin
          errors++; $display("FAIL w8s_spurious got=%h want=none", {es_prod, es_tag});
        end else begin
          if ({es_prod, es_tag} !== qs[0]) begin
            errors++; $display("FAIL w8s_prod got=%h want=%h", {es_prod, es_tag}, qs[0]);
          end
          void'(qs.pop_front());
        end
      end
      if (eu_ovalid) begin
        checks++;
        if (qu.size() == 0) begin
          errors++; $display("FAIL w8u_spurious got=%h want=none", {eu_prod, eu_tag});
        end else begin
          if ({eu_prod, eu_tag} !== qu[0]) begin
            errors++; $display("FAIL w8u_prod got=%h want=%h", {eu_prod, eu_tag}, qu[0]);
          end
          void'(qu.pop_front());
        end
      end
      if (e_valid && es_ready) qs.push_back({ref_mul8(e_a, e_b, 1'b1), e_tag});
      if (e_valid && eu_ready) qu.push_back({ref_mul8(e_a, e_b, 1'b0), e_tag});
      if (e_valid && es_ready && eu_ready) i++;
      cyc++;
    end
    @(negedge clk);
    e_valid = 1'b0;
    checks++; if (i != 65536 || qs.size() != 0 || qu.size() != 0) begin
      errors++; $display("FAIL w8_complete got=%0d/%0d/%0d want=65536/0/0", i, qs.size(), qu.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_rst_inflight();
`ifdef MUL_BOOTH_FLUSH_EN
    test_flush();
`endif
    test_exhaustive8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_booth_pipe.md
Name: mul_booth_pipe

Overview:
- Parametrised radix-4 Booth multiplier with a Wallace/CSA reduction tree and a 4-stage pipeline.
- Supports signed×signed or unsigned×unsigned, selectable per operation.
- Full valid/ready handshake on input and output, with per-stage stall and bubble collapse.
- A user tag rides alongside each operation; serves as the shared multiplier for the datapath and divider-check units.

Parameters:
- WIDTH, 64, operand width in bits; must be even and >= 8.
- TAG_W, 4, width of the sideband tag carried with each operation; minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operation presented.
- in_ready  output  1  block accepts the operation this cycle.
- in_signed  input  1  1 = signed×signed, 0 = unsigned×unsigned.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  result held on out_prod/out_tag.
- out_ready  input  1  consumer takes the result this cycle.
- out_prod  output  2*WIDTH  full product.
- out_tag  output  TAG_W  tag of the result.

Behaviour:
- Reset:
  - One clock, one synchronous active-high reset (rst); no other reset or clock domain.
  - Sampled only on a rising clk edge.
  - Clears all four stage valid flags. out_valid=0, out_prod=0, out_tag=0.
  - in_ready is 1 in the cycle after reset deasserts.
  - Operations in flight when rst is asserted are discarded; no output is produced for them.
- Stages:
  - S0: operand register. Holds a, b, mode, tag.
  - S1: Booth encode plus first CSA levels. Reduces to at most 12 row vectors.
  - S2: remaining CSA levels down to a sum/carry pair.
  - S3: carry-propagate add, registered as out_prod.
  - Data registers load only when their stage advances; valid flags alone are reset.
- Arithmetic:
  - Each operand is extended to WIDTH+2 bits: sign bit if in_signed=1, zeros otherwise.
  - Booth groups: (WIDTH+2)/2 partial products; digits {-2,-1,0,+1,+2}.
  - Negative digits use inversion plus a +1 injected into the carry vector at the group LSB.
  - Accumulation is modulo 2^(2*WIDTH); out_prod is exact for both modes.
- Handshake:
  - Stage k advances when it is valid and stage k+1 is empty or advancing.
  - S3 advances when out_valid && out_ready.
  - in_ready = !v0 || advance0. It is combinational from out_ready through the stall chain; no combinational path from in_valid.
  - Input transfer = in_valid && in_ready. Output transfer = out_valid && out_ready.
  - out_prod/out_tag stay stable while out_valid && !out_ready.
- Latency and throughput:
  - Accept at cycle N gives out_valid at N+4 when no stall occurs.
  - Throughput is one operation per cycle with out_ready held high.
- Stall behaviour:
  - Bubbles collapse: an empty stage is refilled even while downstream is stalled.
  - With out_ready=0, exactly 4 operations are accepted before in_ready drops.
  - Simultaneous out_ready rise and in_valid on a full pipe: the output transfers and the input is accepted in the same cycle.
- Ordering: results leave in acceptance order; each tag stays paired with its own product.

Optional Feature:
- Macro MUL_BOOTH_FLUSH_EN.
- Defined:
  - Adds port flush (input, 1 bit), synchronous and active-high.
  - flush clears v0..v2 and out_valid on the next edge, and blocks input acceptance that cycle (in_ready=0 while flush=1).
  - A result on the output at the same edge as flush is also discarded, even if out_ready=1.
  - rst takes priority over flush.
- Not defined: no flush port; pipeline contents leave only through the output handshake.

Test Plan:
- WIDTH=64, signed, a=-1 (all ones), b=-1, out_ready=1 -> out_prod=1 exactly 4 cycles after accept; tag preserved.
- WIDTH=64, unsigned, a=b=0xFFFF_FFFF_FFFF_FFFF -> out_prod=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001. Same operands signed -> 1.
- Signed, a=0x8000_0000_0000_0000, b=0x8000_0000_0000_0000 -> out_prod=0x4000_0000_0000_0000_0000_0000_0000_0000. Unsigned -> same value. Signed with b=1 -> 0xFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000.
- Back-to-back stream of 20 random ops with tags 0..15 wrapping, and out_ready toggled pseudo-randomly:
  - in_ready drops only after 4 ops are held.
  - No loss, duplication or reorder versus a reference model.
  - out_prod stable while stalled.
- rst pulse for 1 cycle with 3 ops in flight -> out_valid=0 next cycle; none of the 3 results ever appear; the next accepted op completes in 4 cycles.
- WIDTH=8, exhaustive 65536 operand pairs in each mode -> all products match; with MUL_BOOTH_FLUSH_EN, flush with 4 ops in flight -> out_valid=0 next cycle and the pipeline is empty.
